// File: rtl/reg_share_arb_if.sv
// Write-request and shared-register bus between N requesters and reg_share_arb.
// The master side drives requests/locks/data; the slave (arbiter) drives grant and register state.
interface reg_share_arb_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int LW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic [LW-1:0]  q_src;
  logic           q_valid;

  modport master (
    output req, lock, wdata,
    input  gnt, q, q_src, q_valid
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, q, q_src, q_valid
  );
endinterface

// File: rtl/reg_share_arb.sv
// Round-robin arbiter, sole writer of a shared W-bit register; req->q latency 2 edges, locked bursts up to MAX_HOLD.
// No backpressure: a requester holds req until granted; a req dropped while granted releases without a write.
module reg_share_arb #(
  parameter int W        = 8,
  parameter int N        = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  reg_share_arb_if.slave bus
);
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [LW-1:0] ptr;
  logic [LW-1:0] cur;
  logic [LW-1:0] pick;
  logic [HW-1:0] hold_cnt;
  logic          cur_req;
  logic          cur_lock;
  logic [W-1:0]  cur_dat;

  // Scan from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    pick = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (bus.req[ptr + LW'(k)]) pick = ptr + LW'(k);
    end
  end

  assign cur_req  = bus.req[cur];
  assign cur_lock = bus.lock[cur];
  assign cur_dat  = bus.wdata[cur*W +: W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      cur         <= '0;
      hold_cnt    <= '0;
      bus.gnt     <= '0;
      bus.q       <= '0;
      bus.q_src   <= '0;
      bus.q_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.q_valid <= 1'b0;
          if (|bus.req) begin
            bus.gnt  <= ONE << pick;
            cur      <= pick;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          bus.q_valid <= cur_req;
          if (cur_req) begin
            bus.q     <= cur_dat;
            bus.q_src <= cur;
          end
          if (cur_req && cur_lock && (hold_cnt < HOLD_LAST)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            // Pointer moves past the grantee even when it withdrew without writing.
            bus.gnt  <= '0;
            ptr      <= cur + 1'b1;
            hold_cnt <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_share_arb.sv
// Self-checking bench for reg_share_arb: expected writes queued at stimulus time, popped on q_valid.
module tb_reg_share_arb;
  localparam int W = 8;
  localparam int N = 4;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  reg_share_arb_if #(.W(W), .N(N)) bus ();

  reg_share_arb #(.W(W), .N(N), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_slice(input int i, input logic [7:0] v);
    bus.wdata[i*W +: W] = v;
  endtask

  task automatic push(input int src, input logic [7:0] dat);
    exp_t e;
    e.src = 2'(src);
    e.dat = dat;
    sb.push_back(e);
  endtask

  // Scoreboard: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && bus.q_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_src", 32'(bus.q_src), 32'(e.src));
        check("wr_dat", 32'(bus.q), 32'(e.dat));
      end
    end
  end

  initial begin
    logic [3:0] eg;
    bus.req   = '0;
    bus.lock  = '0;
    bus.wdata = '0;

    // Reset state
    tick(); tick();
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_q", 32'(bus.q), 32'd0);
    check("rst_q_src", 32'(bus.q_src), 32'd0);
    check("rst_q_valid", 32'(bus.q_valid), 32'd0);
    rst = 1'b1;

    // Single request
    tick();
    bus.req = 4'b0001;
    set_slice(0, 8'hA5);
    push(0, 8'hA5);
    tick();
    check("single_gnt", 32'(bus.gnt), 32'b0001);
    check("single_vld0", 32'(bus.q_valid), 32'd0);
    tick();
    check("single_gnt_off", 32'(bus.gnt), 32'd0);
    check("single_vld1", 32'(bus.q_valid), 32'd1);
    bus.req = '0;
    tick();
    check("single_vld_end", 32'(bus.q_valid), 32'd0);
    check("single_q_hold", 32'(bus.q), 32'hA5);

    // Round-robin from a fresh pointer
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.req = 4'b1111;
    set_slice(0, 8'h10); set_slice(1, 8'h21); set_slice(2, 8'h32); set_slice(3, 8'h43);
    for (int k = 0; k < 5; k++) push(k % 4, 8'h10 + 8'h11 * 8'(k % 4));
    for (int j = 1; j <= 10; j++) begin
      tick();
      eg = (j % 2 == 1) ? (4'b0001 << (((j - 1) / 2) % 4)) : 4'b0000;
      check("rr_gnt", 32'(bus.gnt), 32'(eg));
      check("rr_vld", 32'(bus.q_valid), (j % 2 == 0) ? 32'd1 : 32'd0);
    end
    bus.req = '0;
    tick();
    check("rr_idle_vld", 32'(bus.q_valid), 32'd0);

    // Locked burst bounded at 4 writes, then requester 3 wins
    bus.req  = 4'b1100;
    bus.lock = 4'b0100;
    for (int j = 1; j <= 5; j++) begin
      tick();
      check("lock_gnt", 32'(bus.gnt), (j <= 4) ? 32'b0100 : 32'd0);
      check("lock_vld", 32'(bus.q_valid), (j >= 2) ? 32'd1 : 32'd0);
      if (j <= 4) begin
        set_slice(2, 8'hB0 + 8'(j - 1));
        push(2, 8'hB0 + 8'(j - 1));
      end
    end
    bus.lock = '0;
    push(3, 8'h43);
    tick();
    check("lock_next_gnt", 32'(bus.gnt), 32'b1000);
    check("lock_next_vld", 32'(bus.q_valid), 32'd0);
    tick();
    check("lock_next_wr", 32'(bus.q_valid), 32'd1);
    bus.req = '0;
    tick();

    // Withdrawal: requester 1 drops req while granted
    bus.req = 4'b0010;
    tick();
    check("wd_gnt", 32'(bus.gnt), 32'b0010);
    bus.req = '0;
    tick();
    check("wd_gnt_rel", 32'(bus.gnt), 32'd0);
    check("wd_no_vld", 32'(bus.q_valid), 32'd0);
    check("wd_q_hold", 32'(bus.q), 32'h43);
    check("wd_src_hold", 32'(bus.q_src), 32'd3);
    bus.req = 4'b0011;
    set_slice(0, 8'h5C);
    push(0, 8'h5C);
    tick();
    check("wd_next_gnt", 32'(bus.gnt), 32'b0001);
    tick();
    check("wd_next_vld", 32'(bus.q_valid), 32'd1);
    bus.req = '0;

    // Wrap-around: after requester 3, requester 0 comes next
    tick();
    bus.req = 4'b1000;
    push(3, 8'h43);
    tick();
    check("wrap_gnt3", 32'(bus.gnt), 32'b1000);
    tick();
    check("wrap_vld3", 32'(bus.q_valid), 32'd1);
    bus.req = 4'b1001;
    push(0, 8'h5C);
    tick();
    check("wrap_gnt0", 32'(bus.gnt), 32'b0001);
    tick();
    check("wrap_vld0", 32'(bus.q_valid), 32'd1);
    bus.req = '0;

    // Asynchronous reset in the middle of a locked burst
    tick();
    bus.req  = 4'b0100;
    bus.lock = 4'b0100;
    set_slice(2, 8'hD1);
    push(2, 8'hD1);
    push(2, 8'hD1);
    tick();
    check("arst_pre_gnt", 32'(bus.gnt), 32'b0100);
    tick();
    check("arst_pre_vld", 32'(bus.q_valid), 32'd1);
    tick();
    check("arst_pre_vld2", 32'(bus.q_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_gnt", 32'(bus.gnt), 32'd0);
    check("arst_q", 32'(bus.q), 32'd0);
    check("arst_q_src", 32'(bus.q_src), 32'd0);
    check("arst_q_valid", 32'(bus.q_valid), 32'd0);
    tick();
    check("arst_hold_gnt", 32'(bus.gnt), 32'd0);
    rst = 1'b1;
    bus.req  = 4'b0110;
    bus.lock = '0;
    push(1, 8'h21);
    tick();
    check("arst_first_gnt", 32'(bus.gnt), 32'b0010);
    tick();
    check("arst_first_vld", 32'(bus.q_valid), 32'd1);
    bus.req = '0;
    tick();

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
